msrv32_fetch_unit: RTL and testbench

//  Reader side of the PC register: consumes the PC and fetches the instruction at that address.

---
 rtl/msrv32_pkg.sv | 13 +
 rtl/msrv32_fetch_fifo.sv | 72 +++++++
 rtl/msrv32_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_msrv32_fetch_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 instruction fetch path.
package msrv32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear and a head read straight
// from the storage flops. A pop on an empty FIFO is ignored; clear wins
// over push and pop in the same cycle.
module msrv32_fetch_fifo
    import msrv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & (count_q != '0);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/msrv32_fetch_unit.sv
// Instruction fetch unit: issues tagged imem requests under a credit limit,
// buffers responses and hands {pc, instr} to decode. A flush empties the
// buffer and arranges for responses still in flight to be dropped.
// Optional feature macro: MSRV32_MISALIGN_TRAP_EN (misaligned PCs become
// NOP marker entries flagged misaligned instead of memory fetches).
module msrv32_fetch_unit
    import msrv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_n_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid_in,
    output logic            pc_ready_out,
    input  logic            flush_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [XLEN-1:0] imem_rdata_in,
    output logic            instr_valid_out,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc_out,
    input  logic            instr_ready_in,
    output logic            instr_misaligned_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [XLEN-1:0] tag_mem_q [DEPTH];
    logic [XLEN-1:0] tag_mem_d [DEPTH];
    logic [PW-1:0]   tag_wr_ptr_q, tag_wr_ptr_d;
    logic [PW-1:0]   tag_rd_ptr_q, tag_rd_ptr_d;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_entry;
    logic            fifo_push;
    logic            fifo_pop;
    logic            space;
    logic            accept;
    logic            misaligned_req;
    logic            trap_accept;

    // Credit uses registered counts only, so a same-cycle pop frees nothing yet
    assign space = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_S;

`ifdef MSRV32_MISALIGN_TRAP_EN
    // A misaligned fetch waits for the memory pipe to drain so the marker stays in order
    assign misaligned_req = pc_valid_in & (pc_in[1:0] != 2'b00);
    assign trap_accept    = misaligned_req & space & (outstanding_q == '0)
                          & ~flush_in & ms_riscv32_mp_rst_n_in;
`else
    assign misaligned_req = 1'b0;
    assign trap_accept    = 1'b0;
`endif

    assign imem_req_out  = pc_valid_in & ~misaligned_req & space & ~flush_in
                         & ms_riscv32_mp_rst_n_in;
    assign imem_addr_out = {pc_in[XLEN-1:2], 2'b00};
    assign accept        = imem_req_out & imem_gnt_in;
    assign pc_ready_out  = accept | trap_accept;

    // Select what enters the instruction buffer this cycle
    always_comb begin
        fifo_entry = '0;
        fifo_push  = 1'b0;
        if (trap_accept) begin
            fifo_push             = 1'b1;
            fifo_entry.pc         = pc_in;
            fifo_entry.instr      = NOP_INSTR;
            fifo_entry.misaligned = 1'b1;
        end else if (imem_rvalid_in && (discard_q == '0) && !flush_in) begin
            fifo_push        = 1'b1;
            fifo_entry.pc    = tag_mem_q[tag_rd_ptr_q];
            fifo_entry.instr = imem_rdata_in;
        end
    end

    assign fifo_pop = instr_valid_out & instr_ready_in;

    // Outstanding/discard counters and the PC-tag ring
    always_comb begin
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid_in);
        discard_d     = discard_q;
        tag_mem_d     = tag_mem_q;
        tag_wr_ptr_d  = tag_wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;
        if (flush_in) begin
            discard_d = outstanding_d;
        end else if (imem_rvalid_in && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (accept) begin
            tag_mem_d[tag_wr_ptr_q] = pc_in;
            tag_wr_ptr_d            = tag_wr_ptr_q + 1'b1;
        end
        if (imem_rvalid_in) begin
            tag_rd_ptr_d = tag_rd_ptr_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
            tag_mem_q     <= tag_mem_d;
        end
    end

    msrv32_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (ms_riscv32_mp_clk_in),
        .rst_n     (ms_riscv32_mp_rst_n_in),
        .push      (fifo_push),
        .push_data (fifo_entry),
        .pop       (fifo_pop),
        .clear     (flush_in),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign instr_valid_out = (fifo_count != '0);
    assign instr_out       = instr_valid_out ? fifo_head.instr : '0;
    assign instr_pc_out    = instr_valid_out ? fifo_head.pc    : '0;

`ifdef MSRV32_MISALIGN_TRAP_EN
    assign instr_misaligned_out = instr_valid_out & fifo_head.misaligned;
`else
    logic unused_misalign_bits;
    assign unused_misalign_bits = &{1'b0, pc_in[1:0], fifo_head.misaligned};
    assign instr_misaligned_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_fetch_unit.sv
// Directed bench for msrv32_fetch_unit (DEPTH=4). Inputs change 1 time unit
// after each rising edge and outputs are sampled 1 unit later.
module tb_msrv32_fetch_unit;
    import msrv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ivalid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        iready;
    logic        imis;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    msrv32_fetch_unit #(.DEPTH(4)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .pc_in                  (pc_in),
        .pc_valid_in            (pc_valid),
        .pc_ready_out           (pc_ready),
        .flush_in               (flush),
        .imem_req_out           (req),
        .imem_addr_out          (addr),
        .imem_gnt_in            (gnt),
        .imem_rvalid_in         (rvalid),
        .imem_rdata_in          (rdata),
        .instr_valid_out        (ivalid),
        .instr_out              (instr),
        .instr_pc_out           (ipc),
        .instr_ready_in         (iready),
        .instr_misaligned_out   (imis)
    );

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic pv, input logic [31:0] pc, input logic g,
                       input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic fl);
        pc_valid = pv;
        pc_in    = pc;
        gnt      = g;
        rvalid   = rv;
        rdata    = rd;
        iready   = rdy;
        flush    = fl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0);
        #10;
        chk("rst_valid", ivalid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", ipc, 0);
        chk("rst_mis", imis, 0);
        chk("rst_req", req, 0);
        chk("rst_pc_ready", pc_ready, 0);
        rst_n = 1'b1;

        // Streaming: gnt=1, rvalid one cycle after gnt, ready=1
        tick(); set(1, 32'h0, 1, 0, 0, 1, 0);
        chk("s_req0", req, 1);
        chk("s_addr0", addr, 32'h0);
        chk("s_acc0", pc_ready, 1);
        chk("s_valid0", ivalid, 0);
        tick(); set(1, 32'h4, 1, 1, w(32'h0), 1, 0);
        chk("s_acc1", pc_ready, 1);
        chk("s_valid1", ivalid, 0);
        tick(); set(1, 32'h8, 1, 1, w(32'h4), 1, 0);
        chk("s_valid2", ivalid, 1);
        chk("s_pc2", ipc, 32'h0);
        chk("s_instr2", instr, w(32'h0));
        chk("s_acc2", pc_ready, 1);
        tick(); set(0, 0, 0, 1, w(32'h8), 1, 0);
        chk("s_valid3", ivalid, 1);
        chk("s_pc3", ipc, 32'h4);
        chk("s_instr3", instr, w(32'h4));
        tick(); set(0, 0, 0, 0, 0, 1, 0);
        chk("s_pc4", ipc, 32'h8);
        chk("s_instr4", instr, w(32'h8));
        tick(); set(0, 0, 0, 0, 0, 0, 0);
        chk("s_empty", ivalid, 0);

        // Backpressure: ready=0, latency 1; exactly DEPTH accepts
        tick(); set(1, 32'h10, 1, 0, 0, 0, 0);
        chk("bp_acc0", pc_ready, 1);
        tick(); set(1, 32'h14, 1, 1, w(32'h10), 0, 0);
        chk("bp_acc1", pc_ready, 1);
        tick(); set(1, 32'h18, 1, 1, w(32'h14), 0, 0);
        chk("bp_acc2", pc_ready, 1);
        tick(); set(1, 32'h1C, 1, 1, w(32'h18), 0, 0);
        chk("bp_acc3", pc_ready, 1);
        tick(); set(1, 32'h20, 1, 1, w(32'h1C), 0, 0);
        chk("bp_stall_rdy", pc_ready, 0);
        chk("bp_stall_req", req, 0);
        tick(); set(1, 32'h20, 1, 0, 0, 1, 0);
        chk("bp_full_rdy", pc_ready, 0);
        chk("bp_count", dut.fifo_count, 4);
        chk("bp_head0", ipc, 32'h10);
        tick(); set(1, 32'h20, 1, 0, 0, 1, 0);
        chk("bp_resume", pc_ready, 1);
        chk("bp_head1", ipc, 32'h14);
        tick(); set(0, 0, 0, 1, w(32'h20), 1, 0);
        chk("bp_head2", ipc, 32'h18);
        tick(); set(0, 0, 0, 0, 0, 1, 0);
        chk("bp_head3", ipc, 32'h1C);
        tick(); set(0, 0, 0, 0, 0, 1, 0);
        chk("bp_head4", ipc, 32'h20);
        chk("bp_instr4", instr, w(32'h20));
        tick(); set(0, 0, 0, 0, 0, 0, 0);
        chk("bp_empty", ivalid, 0);

        // Flush with 2 outstanding and 1 buffered
        tick(); set(1, 32'h30, 1, 0, 0, 0, 0);
        tick(); set(1, 32'h34, 1, 0, 0, 0, 0);
        tick(); set(1, 32'h38, 1, 1, w(32'h30), 0, 0);
        tick(); set(0, 0, 0, 0, 0, 0, 1);
        chk("f_pre_valid", ivalid, 1);
        chk("f_pre_out", dut.outstanding_q, 2);
        chk("f_req", req, 0);
        tick(); set(1, 32'h100, 1, 1, w(32'h34), 0, 0);
        chk("f_valid_t1", ivalid, 0);
        chk("f_discard_t1", dut.discard_q, 2);
        chk("f_acc100", pc_ready, 1);
        tick(); set(0, 0, 0, 1, w(32'h38), 0, 0);
        chk("f_drop1", ivalid, 0);
        chk("f_discard_t2", dut.discard_q, 1);
        tick(); set(0, 0, 0, 1, w(32'h100), 0, 0);
        chk("f_drop2", ivalid, 0);
        chk("f_discard_t3", dut.discard_q, 0);
        tick(); set(0, 0, 0, 0, 0, 1, 0);
        chk("f_new_valid", ivalid, 1);
        chk("f_new_pc", ipc, 32'h100);
        chk("f_new_instr", instr, w(32'h100));
        tick(); set(0, 0, 0, 0, 0, 0, 0);
        chk("f_done", ivalid, 0);
        chk("f_out0", dut.outstanding_q, 0);

        // Flush coinciding with rvalid and pc_valid
        tick(); set(1, 32'h40, 1, 0, 0, 0, 0);
        tick(); set(1, 32'h44, 1, 0, 0, 0, 0);
        tick(); set(1, 32'h48, 1, 1, w(32'h40), 0, 1);
        chk("fc_req", req, 0);
        chk("fc_rdy", pc_ready, 0);
        tick(); set(0, 0, 0, 1, w(32'h44), 0, 0);
        chk("fc_valid", ivalid, 0);
        chk("fc_discard", dut.discard_q, 1);
        chk("fc_out", dut.outstanding_q, 1);
        tick(); set(0, 0, 0, 0, 0, 0, 0);
        chk("fc_valid2", ivalid, 0);
        chk("fc_discard2", dut.discard_q, 0);
        chk("fc_out2", dut.outstanding_q, 0);

        // Reset mid-operation with 3 entries buffered
        tick(); set(1, 32'h50, 1, 0, 0, 0, 0);
        tick(); set(1, 32'h54, 1, 1, w(32'h50), 0, 0);
        tick(); set(1, 32'h58, 1, 1, w(32'h54), 0, 0);
        tick(); set(0, 0, 0, 1, w(32'h58), 0, 0);
        tick(); set(0, 0, 0, 0, 0, 0, 0);
        chk("r_count3", dut.fifo_count, 3);
        chk("r_valid_pre", ivalid, 1);
        rst_n = 1'b0;
        set(1, 32'h60, 1, 0, 0, 0, 0);
        chk("r_valid", ivalid, 0);
        chk("r_instr", instr, 0);
        chk("r_pc", ipc, 0);
        chk("r_mis", imis, 0);
        chk("r_req", req, 0);
        chk("r_rdy", pc_ready, 0);
        chk("r_count", dut.fifo_count, 0);
        chk("r_out", dut.outstanding_q, 0);
        chk("r_disc", dut.discard_q, 0);
        tick();
        rst_n = 1'b1;
        set(1, 32'h0, 1, 0, 0, 1, 0);
        chk("r_acc", pc_ready, 1);
        tick(); set(0, 0, 0, 1, w(32'h0), 1, 0);
        tick(); set(0, 0, 0, 0, 0, 1, 0);
        chk("r_fetch_valid", ivalid, 1);
        chk("r_fetch_pc", ipc, 32'h0);
        chk("r_fetch_instr", instr, w(32'h0));
        tick(); set(0, 0, 0, 0, 0, 0, 0);
        chk("r_fetch_done", ivalid, 0);

        // Misaligned PC 0x6
        tick(); set(1, 32'h6, 1, 0, 0, 0, 0);
`ifdef MSRV32_MISALIGN_TRAP_EN
        chk("m_req", req, 0);
        chk("m_rdy", pc_ready, 1);
        tick(); set(0, 0, 0, 0, 0, 1, 0);
        chk("m_valid", ivalid, 1);
        chk("m_pc", ipc, 32'h6);
        chk("m_instr", instr, 32'h0000_0013);
        chk("m_flag", imis, 1);
`else
        chk("m_req", req, 1);
        chk("m_addr", addr, 32'h4);
        chk("m_rdy", pc_ready, 1);
        tick(); set(0, 0, 0, 1, w(32'h4), 0, 0);
        tick(); set(0, 0, 0, 0, 0, 1, 0);
        chk("m_valid", ivalid, 1);
        chk("m_pc", ipc, 32'h6);
        chk("m_instr", instr, w(32'h4));
        chk("m_flag", imis, 0);
`endif
        tick(); set(0, 0, 0, 0, 0, 0, 0);
        chk("m_done", ivalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
